// File: rtl/datamover_rd_checker_if.sv
// MM2S command, read-stream and status channels between the read checker and the DataMover.
// master = checker side, slave = DataMover side.
interface datamover_rd_checker_if #(
  parameter int DDR_ADDR_WIDTH = 40
);
  logic [DDR_ADDR_WIDTH+39:0] cmd_tdata;
  logic                       cmd_tvalid;
  logic                       cmd_tready;
  logic [63:0]                rd_tdata;
  logic [7:0]                 rd_tkeep;
  logic                       rd_tvalid;
  logic                       rd_tlast;
  logic                       rd_tready;
  logic [7:0]                 sts_tdata;
  logic                       sts_tvalid;
  logic                       sts_tready;

  modport master (
    output cmd_tdata, cmd_tvalid, rd_tready, sts_tready,
    input  cmd_tready, rd_tdata, rd_tkeep, rd_tvalid, rd_tlast, sts_tdata, sts_tvalid
  );

  modport slave (
    input  cmd_tdata, cmd_tvalid, rd_tready, sts_tready,
    output cmd_tready, rd_tdata, rd_tkeep, rd_tvalid, rd_tlast, sts_tdata, sts_tvalid
  );
endinterface

// File: rtl/datamover_rd_checker.sv
// MM2S read checker: issues one read command, checks incrementing-pattern beats and status word.
// Optional macro DATAMOVER_RD_BP_EN: LFSR-driven backpressure on the read stream.
module datamover_rd_checker #(
  parameter int          DDR_ADDR_WIDTH = 40,
  parameter logic [3:0]  CMD_TAG        = 4'hA,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [15:0]               i_length,
  input  logic [DDR_ADDR_WIDTH-1:0] i_start_addr,
  input  logic [63:0]               i_seed,
  datamover_rd_checker_if.master    mm2s,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic                      o_timeout,
  output logic [15:0]               o_err_cnt,
  output logic [15:0]               o_first_err_beat
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_STS, S_DONE} state_t;
  state_t state, state_nxt;

  logic                      start_d, start_edge;
  logic [15:0]               len_q;
  logic [DDR_ADDR_WIDTH-1:0] addr_q;
  logic [15:0]               n_beats;
  logic [15:0]               beat_idx;
  logic [63:0]               exp_data;
  logic [31:0]               wd_cnt;

  logic accept, cmd_hs, beat_hs, sts_hs, any_hs, wd_expire, in_wait;
  logic is_last, beyond, data_bad, beat_bad, beat_err, sts_err, err_event;
  logic [7:0] last_keep, exp_keep;

  // Edge detect is registered, so a start is acted on one cycle after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_d    <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      start_d    <= i_start;
      start_edge <= i_start & ~start_d;
    end
  end

  assign accept = (state == S_IDLE) & start_edge & (i_length != 16'd0);

  assign mm2s.cmd_tvalid = (state == S_CMD);
  assign mm2s.cmd_tdata  = {4'd0, CMD_TAG, addr_q, 1'b0, 1'b1, 6'd0, 1'b1, 7'd0, len_q};
  assign mm2s.sts_tready = (state == S_STS);

`ifdef DATAMOVER_RD_BP_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign mm2s.rd_tready = (state == S_DATA) & lfsr[0];
`else
  assign mm2s.rd_tready = (state == S_DATA);
`endif

  assign cmd_hs  = mm2s.cmd_tvalid & mm2s.cmd_tready;
  assign beat_hs = mm2s.rd_tready & mm2s.rd_tvalid;
  assign sts_hs  = mm2s.sts_tready & mm2s.sts_tvalid;
  assign any_hs  = cmd_hs | beat_hs | sts_hs;

  assign in_wait   = (state == S_CMD) | (state == S_DATA) | (state == S_STS);
  assign wd_expire = in_wait & ~any_hs & (wd_cnt >= TIMEOUT_CYCLES - 32'd1);

  // Beat classification; beats past N carry no expected pattern, they are errors by position.
  assign is_last   = (beat_idx == n_beats - 16'd1);
  assign beyond    = (beat_idx >= n_beats);
  assign last_keep = (len_q[2:0] == 3'd0) ? 8'hFF : ((8'h01 << len_q[2:0]) - 8'h01);
  assign exp_keep  = is_last ? last_keep : 8'hFF;

  always_comb begin
    data_bad = 1'b0;
    for (int b = 0; b < 8; b++)
      if (exp_keep[b] && (mm2s.rd_tdata[8*b +: 8] != exp_data[8*b +: 8]))
        data_bad = 1'b1;
  end

  assign beat_bad  = ~beyond & ((mm2s.rd_tkeep != exp_keep) | data_bad);
  assign beat_err  = beat_bad | beyond
                   | (~is_last & ~beyond & mm2s.rd_tlast)
                   | (is_last & ~mm2s.rd_tlast);
  assign sts_err   = (mm2s.sts_tdata[3:0] != CMD_TAG) | ~mm2s.sts_tdata[7]
                   | (mm2s.sts_tdata[6:4] != 3'd0);
  assign err_event = (beat_hs & beat_err) | (sts_hs & sts_err);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_CMD;
      S_CMD: begin
        if (wd_expire)   state_nxt = S_DONE;
        else if (cmd_hs) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (wd_expire)                     state_nxt = S_DONE;
        else if (beat_hs && mm2s.rd_tlast) state_nxt = S_STS;
      end
      S_STS: begin
        if (wd_expire || sts_hs) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q            <= '0;
      addr_q           <= '0;
      n_beats          <= '0;
      beat_idx         <= '0;
      exp_data         <= '0;
      wd_cnt           <= '0;
      o_pass           <= 1'b0;
      o_timeout        <= 1'b0;
      o_err_cnt        <= '0;
      o_first_err_beat <= 16'hFFFF;
    end else begin
      if (accept || any_hs || !in_wait) wd_cnt <= '0;
      else                              wd_cnt <= wd_cnt + 32'd1;

      if (accept) begin
        len_q            <= i_length;
        addr_q           <= i_start_addr;
        n_beats          <= 16'((17'(i_length) + 17'd7) >> 3);
        exp_data         <= i_seed;
        beat_idx         <= '0;
        o_err_cnt        <= '0;
        o_pass           <= 1'b0;
        o_timeout        <= 1'b0;
        o_first_err_beat <= 16'hFFFF;
      end else begin
        if (beat_hs) begin
          exp_data <= exp_data + 64'd1;
          if (beat_idx != 16'hFFFF) beat_idx <= beat_idx + 16'd1;
          if (beat_bad && o_first_err_beat == 16'hFFFF) o_first_err_beat <= beat_idx;
        end
        if (err_event && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
        if (wd_expire) o_timeout <= 1'b1;
        // Result is set on entry to DONE so it is already valid alongside o_done.
        if (state != S_DONE && state_nxt == S_DONE)
          o_pass <= ~wd_expire & ~err_event & (o_err_cnt == 16'd0);
      end
    end
  end

endmodule
